upower_mc_ctrl: RTL

UPOWER_MC_CTRL -- requirements
Module: upower_mc_ctrl

---
 rtl/upower_mc_ctrl.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/upower_mc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : upower_mc_ctrl
//  Description : Multi-cycle control unit for a small PowerPC-flavoured core.
//                Sequences FETCH -> DECODE -> EXEC -> (MEM) -> (WB) per
//                instruction, drives the instruction/data memory handshakes
//                and the datapath strobes, and traps on illegal opcodes or a
//                data-memory timeout.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Optional feature macro: UPOWER_CTRL_PERF_EN
//      Adds cycle_count / instret_count performance counter outputs.
// ----------------------------------------------------------------------------
//  Ports
//      clk, reset                  : clock, synchronous active-high reset
//      imem_req/addr/rdata/ack     : instruction fetch handshake
//      dmem_req/we/ack             : data memory handshake
//      ir, opcode                  : latched instruction and its top 6 bits
//      branch_taken/target         : ALU branch result, sampled in EXEC
//      alu_en, reg_we, mem_to_reg,
//      lr_we                       : datapath strobes
//      state, trap, trap_cause, pc : status
//      cycle_count, instret_count  : performance counters (macro only)
// ============================================================================
module upower_mc_ctrl #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          MEM_TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    output logic [31:0] ir,
    output logic [5:0]  opcode,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        alu_en,
    output logic        reg_we,
    output logic        mem_to_reg,
    output logic        lr_we,
    output logic [2:0]  state,
    output logic        trap,
    output logic [1:0]  trap_cause,
    output logic [31:0] pc
`ifdef UPOWER_CTRL_PERF_EN
    ,
    output logic [31:0] cycle_count,
    output logic [31:0] instret_count
`endif
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd7
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_pc;
    logic [31:0] r_ir;
    logic [1:0]  r_cause;
    logic [7:0]  r_mem_cnt;

    logic [5:0]  w_op;
    logic        w_is_alu;
    logic        w_is_load;
    logic        w_is_store;
    logic        w_is_branch;
    logic        w_legal;
    logic        w_mem_expire;

    assign w_op = r_ir[31:26];

    // Instruction class decode from the latched opcode.
    always_comb begin
        w_is_alu    = 1'b0;
        w_is_load   = 1'b0;
        w_is_store  = 1'b0;
        w_is_branch = 1'b0;
        case (w_op)
            6'd14, 6'd15, 6'd24, 6'd26, 6'd28, 6'd31: w_is_alu    = 1'b1;
            6'd32, 6'd34, 6'd40, 6'd42, 6'd58:        w_is_load   = 1'b1;
            6'd36, 6'd38, 6'd44, 6'd62:               w_is_store  = 1'b1;
            6'd18, 6'd19:                             w_is_branch = 1'b1;
            default: ;
        endcase
    end

    assign w_legal = w_is_alu | w_is_load | w_is_store | w_is_branch;

    // Counter holds (MEM cycles already spent - 1); on the last allowed cycle
    // a missing ack sends us to TRAP, while an ack on that same cycle wins.
    assign w_mem_expire = (r_mem_cnt == 8'(MEM_TIMEOUT - 1));

    // Next-state and Moore strobe outputs.
    always_comb begin
        w_next     = r_state;
        imem_req   = 1'b0;
        alu_en     = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        reg_we     = 1'b0;
        mem_to_reg = 1'b0;
        lr_we      = 1'b0;
        trap       = 1'b0;
        case (r_state)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) w_next = S_DECODE;
            end
            S_DECODE: begin
                w_next = w_legal ? S_EXEC : S_TRAP;
            end
            S_EXEC: begin
                alu_en = 1'b1;
                if (w_is_alu)                     w_next = S_WB;
                else if (w_is_load || w_is_store) w_next = S_MEM;
                else if (w_is_branch)             w_next = r_ir[0] ? S_WB : S_FETCH;
                else                              w_next = S_TRAP;
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = w_is_store;
                if (dmem_ack)          w_next = w_is_load ? S_WB : S_FETCH;
                else if (w_mem_expire) w_next = S_TRAP;
            end
            S_WB: begin
                // A branch-with-link reaches WB only to write the link register.
                reg_we     = ~w_is_branch;
                lr_we      = w_is_branch;
                mem_to_reg = w_is_load;
                w_next     = S_FETCH;
            end
            S_TRAP: begin
                trap = 1'b1;
            end
            default: begin
                w_next = S_TRAP;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_FETCH;
            r_pc      <= RESET_VECTOR;
            r_ir      <= 32'h0;
            r_cause   <= 2'b00;
            r_mem_cnt <= 8'h0;
        end else begin
            r_state <= w_next;
            if (r_state == S_FETCH && imem_ack) begin
                r_ir <= imem_rdata;
                r_pc <= r_pc + 32'd4;
            end
            if (r_state == S_EXEC && w_is_branch && branch_taken) begin
                r_pc <= branch_target;
            end
            if (r_state == S_DECODE && !w_legal) begin
                r_cause <= 2'b01;
            end
            if (r_state == S_MEM && !dmem_ack && w_mem_expire) begin
                r_cause <= 2'b10;
            end
            if (r_state == S_MEM && w_next == S_MEM) r_mem_cnt <= r_mem_cnt + 8'd1;
            else                                     r_mem_cnt <= 8'h0;
        end
    end

`ifdef UPOWER_CTRL_PERF_EN
    logic [31:0] r_cycle_count;
    logic [31:0] r_instret_count;
    logic        w_retire;

    // Retirement = final transition of an instruction back into FETCH.
    assign w_retire = (w_next == S_FETCH) &&
                      (r_state == S_WB || r_state == S_MEM || r_state == S_EXEC);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cycle_count   <= 32'h0;
            r_instret_count <= 32'h0;
        end else if (r_state != S_TRAP) begin
            r_cycle_count <= r_cycle_count + 32'd1;
            if (w_retire) r_instret_count <= r_instret_count + 32'd1;
        end
    end

    assign cycle_count   = r_cycle_count;
    assign instret_count = r_instret_count;
`endif

    assign state      = r_state;
    assign pc         = r_pc;
    assign imem_addr  = r_pc;
    assign ir         = r_ir;
    assign opcode     = r_ir[31:26];
    assign trap_cause = r_cause;

endmodule
`default_nettype wire
